mux_n1_rr: RTL

//  Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output.
//  Two modes: manual select (sel_in picks the channel) and round-robin (fair rotation over the valid channels).
//  One output register stage; full throughput of one word per cycle.

---
 rtl/mux_pkg.sv | 37 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/mux_n1_rr.sv | 93 +++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and the rotating first-valid search for the N:1 round-robin mux.
// Used by rr_arbiter and mux_n1_rr.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Upper bound on channel count that the search function can handle.
  localparam int MAX_CH    = 32;
  localparam int MAX_IDX_W = 5;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } grant_t;

  // First set bit of valid[n_ch-1:0], scanning ptr, ptr+1, ... modulo n_ch.
  function automatic grant_t f_rot_first(input logic [MAX_CH-1:0]    valid,
                                         input logic [MAX_IDX_W-1:0] ptr,
                                         input int                   n_ch);
    grant_t g;
    int     k;
    g = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (i < n_ch && !g.found) begin
        k = int'(ptr) + i;
        if (k >= n_ch) k = k - n_ch;
        if (valid[k[MAX_IDX_W-1:0]]) begin
          g.found = 1'b1;
          g.idx   = k[MAX_IDX_W-1:0];
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requesting channel at or after ptr.
// The pointer register lives in the parent.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [MAX_CH-1:0]    req_ext;
  logic [MAX_IDX_W-1:0] ptr_ext;
  grant_t               g;
  logic                 unused_idx_hi;

  always_comb begin
    req_ext             = '0;
    req_ext[N_CH-1:0]   = req;
    ptr_ext             = '0;
    ptr_ext[SEL_W-1:0]  = ptr;
  end

  assign g             = f_rot_first(req_ext, ptr_ext, N_CH);
  assign gnt_vld       = g.found;
  assign gnt_idx       = g.idx[SEL_W-1:0];
  assign unused_idx_hi = ^g.idx;

endmodule

// File: rtl/mux_n1_rr.sv
// N-channel registered multiplexer, manual-select or round-robin, with one output stage.
// Optional MUX_PARITY_EN adds a registered even-parity bit of y_out.
module mux_n1_rr
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [N_CH*W-1:0] data_in,
  input  logic [N_CH-1:0]   valid_in,
  output logic [N_CH-1:0]   ready_out,
  input  logic              mode_in,
  input  logic [SEL_W-1:0]  sel_in,
  output logic [W-1:0]      y_out,
  output logic              y_valid_out,
  input  logic              y_ready_in,
`ifdef MUX_PARITY_EN
  output logic              y_parity_out,
`endif
  output logic [SEL_W-1:0]  y_ch_out
);

  // Handshake: a word moves when valid and ready are both high at a rising edge.
  // Producers hold valid/data until accepted; ready_out never depends on the
  // producer's own valid being granted elsewhere, and the output stage accepts
  // a new word whenever it is empty or being drained in the same cycle.

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             ld;
  logic             xfer;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req     (valid_in),
    .ptr     (ptr),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (mode_in == MODE_RR) begin
      gnt_vld = rr_vld;
      gnt_idx = rr_idx;
    end else if (int'(sel_in) < N_CH) begin
      gnt_vld = valid_in[sel_in];
      gnt_idx = sel_in;
    end
  end

  assign ld   = !y_valid_out || y_ready_in;
  assign xfer = gnt_vld && ld && rst_n_in;

  // Reset is async, so ready must be forced low combinationally while it is held.
  always_comb begin
    ready_out = '0;
    if (xfer) ready_out[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      y_out       <= '0;
      y_ch_out    <= '0;
      y_valid_out <= 1'b0;
      ptr         <= '0;
    end else if (xfer) begin
      y_out       <= data_in[gnt_idx*W +: W];
      y_ch_out    <= gnt_idx;
      y_valid_out <= 1'b1;
      if (mode_in == MODE_RR) begin
        if (int'(gnt_idx) == N_CH-1) ptr <= '0;
        else                         ptr <= gnt_idx + 1'b1;
      end
    end else if (y_ready_in) begin
      y_valid_out <= 1'b0;
    end
  end

`ifdef MUX_PARITY_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)  y_parity_out <= 1'b0;
    else if (xfer) y_parity_out <= ^data_in[gnt_idx*W +: W];
  end
`endif

endmodule
